// File: rtl/loader_defs.sv
// Shared definitions for the serial instruction-memory boot loader:
// receiver/loader state encodings, header and word sizing, frame length.
package loader_defs;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_BITS  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] LD_HDR_HI = 3'd0;
  localparam logic [2:0] LD_HDR_LO = 3'd1;
  localparam logic [2:0] LD_DATA   = 3'd2;
  localparam logic [2:0] LD_CSUM   = 3'd3;
  localparam logic [2:0] LD_DONE   = 3'd4;
  localparam logic [2:0] LD_ERROR  = 3'd5;

  localparam int HDR_W          = 16;
  localparam int BYTES_PER_WORD = 4;
  localparam int FRAME_BITS     = 10;

  // Big-endian assembly: the first byte of a word ends up in [31:24].
  function automatic logic [31:0] push_byte(
    input logic [31:0] w,
    input logic [7:0]  b
  );
    return {w[23:0], b};
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with a 2-flop rx synchronizer.
// Ports: clock, reset (sync, active-high), rx -> byte_valid, byte_data, frame_error.
module uart_rx_byte
  import loader_defs::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_error
);

  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int DBITS = FRAME_BITS - 2;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic          rx_m_q, rx_s_q;
  logic [1:0]    st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          bv_q, bv_d;
  logic          fe_q, fe_d;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    sh_d  = sh_q;
    bv_d  = 1'b0;
    fe_d  = 1'b0;
    unique case (st_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) st_d = RX_START;
      end
      RX_START: begin
        // Recheck mid start bit; a high line here was a glitch.
        if (cnt_q == HALF) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = rx_s_q ? RX_IDLE : RX_BITS;
        end
      end
      RX_BITS: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          sh_d  = {rx_s_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'(DBITS - 1)) st_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          st_d  = RX_IDLE;
          bv_d  = rx_s_q;
          fe_d  = !rx_s_q;
        end
      end
      default: st_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
      st_q   <= RX_IDLE;
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      bv_q   <= 1'b0;
      fe_q   <= 1'b0;
    end else begin
      rx_m_q <= rx;
      rx_s_q <= rx_m_q;
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      bv_q   <= bv_d;
      fe_q   <= fe_d;
    end
  end

  assign byte_valid  = bv_q;
  assign byte_data   = sh_q;
  assign frame_error = fe_q;

endmodule

// File: rtl/imem_loader.sv
// UART boot loader: 16-bit word-count header, big-endian words, imem writes.
// Ports: clock, reset, rx -> wr_en/wr_addr/wr_data, busy, done, cpu_hold,
// word_count, overflow, frame_err, csum_err. IMEM_LOADER_CHECKSUM_EN adds
// a trailing XOR checksum byte.
module imem_loader
  import loader_defs::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold,
  output logic [HDR_W-1:0]  word_count,
  output logic              overflow,
  output logic              frame_err,
  output logic              csum_err
);

  localparam logic [31:0] CAP = 32'(1) << ADDR_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] LD_END = LD_CSUM;
`else
  localparam logic [2:0] LD_END = LD_DONE;
`endif

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_error;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_error(frame_error)
  );

  logic [2:0]       st_q, st_d;
  logic [7:0]       hi_q, hi_d;
  logic [HDR_W-1:0] wc_q, wc_d;
  logic [1:0]       bidx_q, bidx_d;
  logic [HDR_W:0]   widx_q, widx_d;
  logic [31:0]      word_q, word_d;
  logic             wen_q, wen_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             ovf_q, ovf_d;
  logic             ferr_q, ferr_d;
  logic [HDR_W-1:0] hdr;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
  logic             cerr_q, cerr_d;
`endif

  assign hdr = {hi_q, byte_data};

  always_comb begin
    st_d    = st_q;
    hi_d    = hi_q;
    wc_d    = wc_q;
    bidx_d  = bidx_q;
    widx_d  = widx_q;
    word_d  = word_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    ovf_d   = ovf_q;
    ferr_d  = ferr_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
    cerr_d  = cerr_q;
`endif
    if (frame_error && st_q != LD_DONE && st_q != LD_ERROR) begin
      st_d   = LD_ERROR;
      ferr_d = 1'b1;
    end else if (byte_valid) begin
      unique case (st_q)
        LD_HDR_HI: begin
          hi_d = byte_data;
          st_d = LD_HDR_LO;
        end
        LD_HDR_LO: begin
          wc_d   = hdr;
          widx_d = '0;
          bidx_d = '0;
          ovf_d  = 32'(hdr) > CAP;
          st_d   = (hdr == '0) ? LD_END : LD_DATA;
        end
        LD_DATA: begin
          word_d = push_byte(word_q, byte_data);
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'(BYTES_PER_WORD - 1)) begin
            widx_d = widx_q + 1'b1;
            // Words past capacity are consumed but never written.
            if (32'(widx_q) < CAP) begin
              wen_d   = 1'b1;
              waddr_d = ADDR_W'(widx_q);
              wdata_d = word_d;
            end
            if (widx_d == {1'b0, wc_q}) st_d = LD_END;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        LD_CSUM: begin
          if (byte_data == csum_q) begin
            st_d = LD_DONE;
          end else begin
            st_d   = LD_ERROR;
            cerr_d = 1'b1;
          end
        end
`endif
        default: ;
      endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (st_q inside {LD_HDR_HI, LD_HDR_LO, LD_DATA})
        csum_d = csum_q ^ byte_data;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q    <= LD_HDR_HI;
      hi_q    <= '0;
      wc_q    <= '0;
      bidx_q  <= '0;
      widx_q  <= '0;
      word_q  <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
      cerr_q  <= 1'b0;
`endif
    end else begin
      st_q    <= st_d;
      hi_q    <= hi_d;
      wc_q    <= wc_d;
      bidx_q  <= bidx_d;
      widx_q  <= widx_d;
      word_q  <= word_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
      cerr_q  <= cerr_d;
`endif
    end
  end

  assign wr_en      = wen_q;
  assign wr_addr    = waddr_q;
  assign wr_data    = wdata_q;
  assign word_count = wc_q;
  assign overflow   = ovf_q;
  assign frame_err  = ferr_q;
  assign done       = (st_q == LD_DONE);
  assign cpu_hold   = !done;
  assign busy       = st_q inside {LD_HDR_LO, LD_DATA, LD_CSUM};
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign csum_err   = cerr_q;
`else
  assign csum_err   = 1'b0;
`endif

endmodule
